ysyx_25040109_sram_slave: RTL
=============================

Name: ysyx_25040109_sram_slave

Overview:
- Memory-side responder for the core's AXI4-lite-style fetch/load-store port.
- Serves read requests on the AR/R channels and write requests on the AW/W/B channels.
- Backed by an internal word array, with programmable response latency per channel.
- Sits opposite IFU/LSU.
- The write path exercises the AW/W/B channels the fetch unit ties off.

Parameters:
- DEPTH, 1024: number of 32-bit words (power of two).
- BASE, 32'h8000_0000: byte address of word 0.
- RD_LAT, 2: extra cycles between AR handshake and rvalid (0..15).
- WR_LAT, 2: extra cycles between AW+W capture and bvalid (0..15).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- araddr  in  32  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  read response: 00 OKAY, 10 SLVERR
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  32  write address
- awid  in  4  write transaction id
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstr  in  4  byte strobes; bit i enables byte i
- wlast  in  1  must be 1 (single beat)
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bid  out  4  echo of captured awid
- bvalid  out  1  write response valid
- bready  in  1  write response ready

Behaviour:
- **Reset:** reset low asynchronously forces both FSMs to IDLE.
  - rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, bid=0, all counters 0.
  - Memory array is not reset.
  - Reset mid-transaction discards the pending request: no response, no array write.
- **Decode:**
  - In range iff BASE <= addr < BASE+4*DEPTH; word index = (addr-BASE)[log2(DEPTH)+1:2].
  - addr[1:0] is ignored.
  - Out of range: response 2'b10, rdata=0, no write.
- **Read FSM R_IDLE -> R_WAIT -> R_RESP:**
  - arready=1 only in R_IDLE (combinational from state).
  - arvalid&arready at edge N: latch address; counter=RD_LAT; enter R_WAIT.
  - R_WAIT decrements the counter. When the counter is 0, the next edge samples the array into rdata/rresp and enters R_RESP. rvalid therefore first asserts at cycle N+1+RD_LAT.
  - R_RESP holds rvalid, rdata and rresp stable until rready. On rvalid&rready, go to R_IDLE; the next AR can be accepted one cycle later.
- **Write FSM W_IDLE -> W_WAIT -> W_RESP:**
  - In W_IDLE, AW and W are captured independently, in either order or the same cycle.
    - awready=1 while AW is not yet captured; wready=1 while W is not yet captured.
    - Each ready drops after its own handshake.
  - When both are captured, load counter=WR_LAT and enter W_WAIT.
  - When the counter is 0, the next edge:
    - commits bytes with wstr=1 to the array (only if in range and wlast=1);
    - sets bresp (10 if out of range or wlast=0, else 00) and bid=awid;
    - enters W_RESP.
  - bvalid is held until bready; then W_IDLE, with both capture flags cleared.
- **Channel independence:**
  - The read and write FSMs run concurrently.
  - If the write commit and the read sample hit the same word on the same edge, the read returns the pre-write value.
  - A read sampled on any later edge returns the new value.
- **Other cases:**
  - wstr=4'b0000: OKAY response, array unchanged.
  - Back-to-back requests are not pipelined: at most one outstanding per channel.

Test Plan:
1. Reset low mid-R_WAIT, release -> rvalid stays 0, arready=1 next cycle, no stale response.
2. Write BASE+0x10, data 0xDEAD_BEEF, wstr 4'hF, awid 4'h5, AW two cycles before W -> bvalid at W-capture+1+WR_LAT, bresp 00, bid 5. Then read BASE+0x10 -> rdata 0xDEAD_BEEF, rresp 00, rvalid at AR+3 (RD_LAT=2).
3. Partial write 0x0000_00AA with wstr 4'b0001 to the same word -> read returns 0xDEAD_BEAA.
4. Read address 0x0000_0000 -> rresp 10, rdata 0. Write BASE+4*DEPTH -> bresp 10, no word of the array changes.
5. rready held low 5 cycles after rvalid -> rvalid/rdata stable for all 5 cycles, arready stays 0. After rready, arready=1 next cycle.
6. Read and write to the same word timed so the write commit and read sample hit the same edge (write old 0x1111_1111, new 0x2222_2222) -> read returns 0x1111_1111. Repeat read -> 0x2222_2222.

Source files
------------

// File: rtl/ysyx_25040109_sram_slave.sv
// Memory-side AXI4-lite-style responder: independent read and write FSMs over a
// word array, each answering after a fixed per-channel latency.
module ysyx_25040109_sram_slave #(
  parameter int unsigned DEPTH  = 1024,
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstr,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  output logic        bvalid,
  input  logic        bready
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

  logic [31:0] mem [DEPTH];

  r_state_e    r_state_q, r_state_d;
  logic [3:0]  r_cnt_q, r_cnt_d;
  logic [31:0] raddr_q, raddr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  w_state_e    w_state_q, w_state_d;
  logic [3:0]  w_cnt_q, w_cnt_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstr_q, wstr_d;
  logic [3:0]  wid_q, wid_d;
  logic        wlast_q, wlast_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [3:0]  bid_q, bid_d;

  logic [31:0]   r_off, w_off;
  logic          r_in, w_in, w_ok, w_commit;
  logic [AW-1:0] r_idx, w_idx;
  logic          unused_ok;

  // Offset compare handles a window that ends at the top of the 32-bit space.
  always_comb begin
    r_off    = raddr_q - BASE;
    w_off    = waddr_q - BASE;
    r_in     = (raddr_q >= BASE) && (r_off[31:AW+2] == '0);
    w_in     = (waddr_q >= BASE) && (w_off[31:AW+2] == '0);
    r_idx    = r_off[AW+1:2];
    w_idx    = w_off[AW+1:2];
    w_ok     = w_in && wlast_q;
    w_commit = (w_state_q == W_WAIT) && (w_cnt_q == '0);
  end

  assign unused_ok = ^{r_off[1:0], w_off[1:0]};

  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = (w_state_q == W_IDLE) && !aw_got_q;
  assign wready  = (w_state_q == W_IDLE) && !w_got_q;
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bresp_q;
  assign bid     = bid_q;

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: if (arvalid) begin
        raddr_d   = araddr;
        r_cnt_d   = 4'(RD_LAT);
        r_state_d = R_WAIT;
      end
      R_WAIT: if (r_cnt_q == '0) begin
        rdata_d   = r_in ? mem[r_idx] : '0;
        rresp_d   = r_in ? 2'b00 : 2'b10;
        r_state_d = R_RESP;
      end else begin
        r_cnt_d = r_cnt_q - 4'd1;
      end
      R_RESP: if (rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstr_d    = wstr_q;
    wid_d     = wid_q;
    wlast_d   = wlast_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && !aw_got_q) begin
          aw_got_d = 1'b1;
          waddr_d  = awaddr;
          wid_d    = awid;
        end
        if (wvalid && !w_got_q) begin
          w_got_d = 1'b1;
          wdata_d = wdata;
          wstr_d  = wstr;
          wlast_d = wlast;
        end
        if (aw_got_d && w_got_d) begin
          w_cnt_d   = 4'(WR_LAT);
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: if (w_commit) begin
        bresp_d   = w_ok ? 2'b00 : 2'b10;
        bid_d     = wid_q;
        w_state_d = W_RESP;
      end else begin
        w_cnt_d = w_cnt_q - 4'd1;
      end
      W_RESP: if (bready) begin
        aw_got_d  = 1'b0;
        w_got_d   = 1'b0;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      raddr_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstr_q    <= '0;
      wid_q     <= '0;
      wlast_q   <= 1'b0;
      bresp_q   <= '0;
      bid_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstr_q    <= wstr_d;
      wid_q     <= wid_d;
      wlast_q   <= wlast_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
    end
  end

  // Array is not reset; the commit is gated by FSM state, which reset clears.
  always_ff @(posedge clock) begin
    if (w_commit && w_ok) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstr_q[i]) mem[w_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end
endmodule
